// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/note-off commands onto NUM_VOICES
// frequency generators, stealing the oldest voice when all are busy.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int DIV_WIDTH  = 19
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             note_valid,
   output logic                             note_ready,
   input  logic                             note_on,
   input  logic [DIV_WIDTH-1:0]             note_divider,
   output logic [NUM_VOICES-1:0]            voice_enable,
   output logic [NUM_VOICES*DIV_WIDTH-1:0]  voice_divider,
   output logic                             steal_pulse,
   output logic                             drop_pulse
);

   localparam int AGE_W = $clog2(NUM_VOICES);
   localparam int IDX_W = $clog2(NUM_VOICES);

   typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_GAP} state_t;

   state_t                                 state_q, state_d;
   logic                                   cmd_on_q, cmd_on_d;
   logic [DIV_WIDTH-1:0]                   cmd_div_q, cmd_div_d;
   logic [NUM_VOICES-1:0]                  en_q, en_d;
   logic [NUM_VOICES-1:0][DIV_WIDTH-1:0]   div_q, div_d;
   logic [NUM_VOICES-1:0][AGE_W-1:0]       age_q, age_d;
   logic [IDX_W-1:0]                       gap_idx_q, gap_idx_d;
   logic                                   steal_q, steal_d;
   logic                                   drop_q, drop_d;

   logic                                   match_hit, free_hit;
   logic [IDX_W-1:0]                       match_idx, free_idx, old_idx;
   logic [AGE_W-1:0]                       old_age_max;

   logic                                   make_young, release_voice;
   logic [IDX_W-1:0]                       tgt_idx;
   logic [AGE_W:0]                         tgt_old_age;

   // Voice search: descending scan so the lowest index wins for match/free.
   always_comb begin
      match_hit   = 1'b0;
      match_idx   = '0;
      free_hit    = 1'b0;
      free_idx    = '0;
      old_idx     = '0;
      old_age_max = age_q[0];
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (en_q[v] && (div_q[v] == cmd_div_q)) begin
            match_hit = 1'b1;
            match_idx = IDX_W'(v);
         end
         if (!en_q[v]) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(v);
         end
      end
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (age_q[v] > old_age_max) begin
            old_age_max = age_q[v];
            old_idx     = IDX_W'(v);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cmd_on_d      = cmd_on_q;
      cmd_div_d     = cmd_div_q;
      en_d          = en_q;
      div_d         = div_q;
      age_d         = age_q;
      gap_idx_d     = gap_idx_q;
      steal_d       = 1'b0;
      drop_d        = 1'b0;
      make_young    = 1'b0;
      release_voice = 1'b0;
      tgt_idx       = '0;
      tgt_old_age   = '0;

      case (state_q)
         S_IDLE: begin
            if (note_valid) begin
               cmd_on_d  = note_on;
               cmd_div_d = note_divider;
               state_d   = S_DECIDE;
            end
         end
         S_DECIDE: begin
            state_d = S_IDLE;
            if (cmd_div_q == '0) begin
               drop_d = 1'b1;
            end else if (cmd_on_q) begin
               if (match_hit) begin
                  en_d[match_idx] = 1'b0;
                  make_young      = 1'b1;
                  tgt_idx         = match_idx;
                  tgt_old_age     = {1'b0, age_q[match_idx]};
                  gap_idx_d       = match_idx;
                  state_d         = S_GAP;
               end else if (free_hit) begin
                  en_d[free_idx]  = 1'b1;
                  div_d[free_idx] = cmd_div_q;
                  make_young      = 1'b1;
                  tgt_idx         = free_idx;
                  tgt_old_age     = (AGE_W + 1)'(NUM_VOICES);
               end else begin
                  en_d[old_idx]   = 1'b0;
                  div_d[old_idx]  = cmd_div_q;
                  make_young      = 1'b1;
                  tgt_idx         = old_idx;
                  tgt_old_age     = {1'b0, age_q[old_idx]};
                  gap_idx_d       = old_idx;
                  steal_d         = 1'b1;
                  state_d         = S_GAP;
               end
            end else if (match_hit) begin
               en_d[match_idx] = 1'b0;
               release_voice   = 1'b1;
               tgt_idx         = match_idx;
            end else begin
               drop_d = 1'b1;
            end
         end
         S_GAP: begin
            en_d[gap_idx_q] = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (make_young) begin
         for (int w = 0; w < NUM_VOICES; w++) begin
            if ((w != int'(tgt_idx)) && en_q[w] && ({1'b0, age_q[w]} < tgt_old_age))
               age_d[w] = age_q[w] + AGE_W'(1);
         end
         age_d[tgt_idx] = '0;
      end

      // Releasing a voice closes the hole in the age order so the active
      // ages stay 0..k-1 and a later fresh allocation cannot overflow them.
      if (release_voice) begin
         for (int w = 0; w < NUM_VOICES; w++) begin
            if (en_q[w] && (age_q[w] > age_q[tgt_idx]))
               age_d[w] = age_q[w] - AGE_W'(1);
         end
         age_d[tgt_idx] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cmd_on_q  <= 1'b0;
         cmd_div_q <= '0;
         en_q      <= '0;
         div_q     <= '0;
         age_q     <= '0;
         gap_idx_q <= '0;
         steal_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_on_q  <= cmd_on_d;
         cmd_div_q <= cmd_div_d;
         en_q      <= en_d;
         div_q     <= div_d;
         age_q     <= age_d;
         gap_idx_q <= gap_idx_d;
         steal_q   <= steal_d;
         drop_q    <= drop_d;
      end
   end

   assign note_ready   = (state_q == S_IDLE) && !reset;
   assign voice_enable = en_q;
   assign steal_pulse  = steal_q;
   assign drop_pulse   = drop_q;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_div_out
      assign voice_divider[gi*DIV_WIDTH +: DIV_WIDTH] = div_q[gi];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, steal, retrigger, note-off,
// drops, accept spacing and reset during a gap.
module tb_voice_allocator;

   localparam int NV = 4;
   localparam int DW = 19;

   logic              clk;
   logic              reset;
   logic              note_valid;
   logic              note_ready;
   logic              note_on;
   logic [DW-1:0]     note_divider;
   logic [NV-1:0]     voice_enable;
   logic [NV*DW-1:0]  voice_divider;
   logic              steal_pulse;
   logic              drop_pulse;

   int checks = 0;
   int errors = 0;

   voice_allocator #(.NUM_VOICES(NV), .DIV_WIDTH(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .note_valid    (note_valid),
      .note_ready    (note_ready),
      .note_on       (note_on),
      .note_divider  (note_divider),
      .voice_enable  (voice_enable),
      .voice_divider (voice_divider),
      .steal_pulse   (steal_pulse),
      .drop_pulse    (drop_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] vdiv(input int v);
      return voice_divider[v*DW +: DW];
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      reset      = 1'b1;
      note_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // Returns at the falling edge after E1 (DECIDE result registered).
   task automatic send_cmd(input logic on, input logic [DW-1:0] div);
      int n;
      n = 0;
      while (!note_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_before_cmd", note_ready, 1);
      note_on      = on;
      note_divider = div;
      note_valid   = 1'b1;
      @(negedge clk);
      note_valid = 1'b0;
      check_eq("ready_in_decide", note_ready, 0);
      @(negedge clk);
      $display("cmd %s div=%0d -> en=%b steal=%0d drop=%0d ready=%0d",
               on ? "on " : "off", div, voice_enable, steal_pulse, drop_pulse, note_ready);
   endtask

   task automatic fill4();
      logic [DW-1:0] tbl [4];
      tbl = '{19'd1000, 19'd2000, 19'd3000, 19'd4000};
      for (int i = 0; i < 4; i++) begin
         send_cmd(1'b1, tbl[i]);
         check_eq($sformatf("fill_div%0d", i), vdiv(i), tbl[i]);
      end
      check_eq("fill_en", voice_enable, 4'b1111);
   endtask

   initial begin
      reset        = 1'b1;
      note_valid   = 1'b0;
      note_on      = 1'b0;
      note_divider = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", note_ready, 0);
      check_eq("rst_en", voice_enable, 0);
      check_eq("rst_div_zero", (voice_divider == '0), 1);
      check_eq("rst_steal", steal_pulse, 0);
      check_eq("rst_drop", drop_pulse, 0);
      reset = 1'b0;
      #1;
      check_eq("ready_after_rst", note_ready, 1);

      // Single note-on
      send_cmd(1'b1, 19'd1000);
      check_eq("on1_en", voice_enable, 4'b0001);
      check_eq("on1_div0", vdiv(0), 1000);
      check_eq("on1_ready_e1", note_ready, 1);

      // Fill remaining voices, then steal the oldest (voice0)
      send_cmd(1'b1, 19'd2000);
      send_cmd(1'b1, 19'd3000);
      send_cmd(1'b1, 19'd4000);
      check_eq("fill_en", voice_enable, 4'b1111);
      check_eq("fill_div3", vdiv(3), 4000);
      send_cmd(1'b1, 19'd5000);
      check_eq("steal_pulse_e1", steal_pulse, 1);
      check_eq("steal_en_e1", voice_enable, 4'b1110);
      check_eq("steal_div0", vdiv(0), 5000);
      check_eq("steal_div1_kept", vdiv(1), 2000);
      check_eq("steal_ready_e1", note_ready, 0);
      @(negedge clk);
      check_eq("steal_en_e2", voice_enable, 4'b1111);
      check_eq("steal_pulse_e2", steal_pulse, 0);
      check_eq("steal_ready_e2", note_ready, 1);

      // Retrigger voice0, then a later steal takes voice1
      reset_dut();
      send_cmd(1'b1, 19'd1000);
      send_cmd(1'b1, 19'd2000);
      send_cmd(1'b1, 19'd1000);
      check_eq("retrig_en_e1", voice_enable, 4'b0010);
      check_eq("retrig_no_steal", steal_pulse, 0);
      check_eq("retrig_div0", vdiv(0), 1000);
      check_eq("retrig_div1", vdiv(1), 2000);
      @(negedge clk);
      check_eq("retrig_en_e2", voice_enable, 4'b0011);
      send_cmd(1'b1, 19'd3000);
      send_cmd(1'b1, 19'd4000);
      check_eq("retrig_fill_en", voice_enable, 4'b1111);
      check_eq("retrig_fill_div2", vdiv(2), 3000);
      send_cmd(1'b1, 19'd6000);
      check_eq("steal_v1_pulse", steal_pulse, 1);
      check_eq("steal_v1_en", voice_enable, 4'b1101);
      check_eq("steal_v1_div", vdiv(1), 6000);
      check_eq("steal_v1_div0_kept", vdiv(0), 1000);
      @(negedge clk);
      check_eq("steal_v1_en_e2", voice_enable, 4'b1111);

      // Note-off match and no-match
      reset_dut();
      send_cmd(1'b1, 19'd1000);
      send_cmd(1'b1, 19'd2000);
      send_cmd(1'b0, 19'd2000);
      check_eq("off_en", voice_enable, 4'b0001);
      check_eq("off_div1_kept", vdiv(1), 2000);
      check_eq("off_no_drop", drop_pulse, 0);
      send_cmd(1'b0, 19'd7777);
      check_eq("off_miss_drop", drop_pulse, 1);
      check_eq("off_miss_en", voice_enable, 4'b0001);
      @(negedge clk);
      check_eq("drop_one_cycle", drop_pulse, 0);

      // Divider zero is dropped
      send_cmd(1'b1, 19'd0);
      check_eq("zero_drop", drop_pulse, 1);
      check_eq("zero_en", voice_enable, 4'b0001);
      check_eq("zero_div0", vdiv(0), 1000);
      check_eq("zero_div1", vdiv(1), 2000);

      // note_valid held high: accepts spaced 2 cycles, 3 when gapped
      @(negedge clk);
      check_eq("hold_ready0", note_ready, 1);
      note_valid   = 1'b1;
      note_on      = 1'b1;
      note_divider = 19'd2000;
      @(negedge clk);
      note_divider = 19'd1000;
      check_eq("hold_decide1", note_ready, 0);
      @(negedge clk);
      check_eq("hold_ready_2cyc", note_ready, 1);
      check_eq("hold_en_a", voice_enable, 4'b0011);
      @(negedge clk);
      note_divider = 19'd3000;
      check_eq("hold_decide2", note_ready, 0);
      @(negedge clk);
      check_eq("hold_gap_ready", note_ready, 0);
      check_eq("hold_gap_en", voice_enable, 4'b0010);
      @(negedge clk);
      check_eq("hold_ready_3cyc", note_ready, 1);
      check_eq("hold_gap_done_en", voice_enable, 4'b0011);
      @(negedge clk);
      note_valid = 1'b0;
      @(negedge clk);
      check_eq("hold_last_en", voice_enable, 4'b0111);
      check_eq("hold_last_div2", vdiv(2), 3000);
      $display("hold sequence done en=%b", voice_enable);

      // Reset during the gap of a steal
      reset_dut();
      fill4();
      send_cmd(1'b1, 19'd5000);
      check_eq("gap_rst_steal_e1", steal_pulse, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("gap_rst_en", voice_enable, 0);
      check_eq("gap_rst_div_zero", (voice_divider == '0), 1);
      check_eq("gap_rst_no_steal", steal_pulse, 0);
      check_eq("gap_rst_ready_low", note_ready, 0);
      reset = 1'b0;
      #1;
      check_eq("gap_rst_ready", note_ready, 1);
      @(negedge clk);
      check_eq("gap_rst_steal_after", steal_pulse, 0);
      check_eq("gap_rst_en_after", voice_enable, 0);
      $display("reset during gap done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
